fetch_queue: RTL and testbench

Parametrised instruction fetch unit with a prefetch queue. It generates byte addresses for a synchronous-read instruction memory that has fixed 1-cycle latency, and decodes the length of each returned 32-bit parcel: 32-bit if bits [31:30] = 2'b11, otherwise 16-bit. Fetched instructions are buffered in a DEPTH-entry FIFO and handed to decode over a valid/ready handshake. The block accepts branch redirects, which flush the queue, and sustains one instruction per cycle.

---
 rtl/fetch_queue.sv | 128 ++++++++++++
 tb/tb_fetch_queue.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch unit: issues parcel reads to a 1-cycle-latency memory, decodes 16/32-bit
// length, and buffers fetched instructions in a DEPTH-entry show-ahead queue.
module fetch_queue #(
  parameter int unsigned     XLEN     = 64,
  parameter int unsigned     ADDR_W   = 8,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [31:0]       mem_rdata_i,
  input  logic              redirect_valid_i,
  input  logic [XLEN-1:0]   redirect_pc_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [XLEN-1:0]   out_pc_o,
  output logic [31:0]       out_instr_o,
  output logic              out_len32_o
);

  localparam int unsigned     PtrW     = $clog2(DEPTH);
  localparam logic [PtrW:0]   DepthCnt = (PtrW + 1)'(DEPTH);
  localparam logic [XLEN-1:0] EvenMask = ~XLEN'(1);

  localparam logic [0:0] StIssue = 1'b0;
  localparam logic [0:0] StWait  = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic [PtrW:0]   count_q, count_d;
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;

  logic [XLEN-1:0] pc_q    [DEPTH];
  logic [31:0]     instr_q [DEPTH];
  logic [DEPTH-1:0] len_q;

  logic            len32, push, pop, space, req;
  logic [XLEN-1:0] npc, req_addr;
  logic [31:0]     instr_fmt;

  always_comb begin
    len32     = (mem_rdata_i[31:30] == 2'b11);
    instr_fmt = len32 ? mem_rdata_i : {mem_rdata_i[31:16], 16'h0000};
    npc       = req_pc_q + (len32 ? XLEN'(4) : XLEN'(2));

    out_valid_o = rst_ni & (count_q != '0);
    pop         = out_valid_o & out_ready_i & ~redirect_valid_i;
    push        = (state_q == StWait) & ~redirect_valid_i;
    count_d     = count_q + (PtrW + 1)'(push) - (PtrW + 1)'(pop);
    // Issue only when the response next cycle is guaranteed a slot.
    space       = (count_d < DepthCnt);

    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    req        = 1'b0;
    req_addr   = fetch_pc_q;

    if (redirect_valid_i) begin
      req      = 1'b1;
      req_addr = redirect_pc_i & EvenMask;
      req_pc_d = req_addr;
      state_d  = StWait;
    end else if (state_q == StIssue) begin
      if (space) begin
        req      = 1'b1;
        req_addr = fetch_pc_q;
        req_pc_d = req_addr;
        state_d  = StWait;
      end
    end else begin
      if (space) begin
        req      = 1'b1;
        req_addr = npc;
        req_pc_d = req_addr;
      end else begin
        fetch_pc_d = npc;
        state_d    = StIssue;
      end
    end

    mem_req_o  = rst_ni & req;
    mem_addr_o = req_addr[ADDR_W-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= StIssue;
      fetch_pc_q <= RESET_PC & EvenMask;
      req_pc_q   <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      if (redirect_valid_i) begin
        count_q  <= '0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        count_q <= count_d;
        if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
    end
  end

  // Storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk_i) begin
    if (rst_ni && push) begin
      pc_q[wr_ptr_q]    <= req_pc_q;
      instr_q[wr_ptr_q] <= instr_fmt;
      len_q[wr_ptr_q]   <= len32;
    end
  end

  always_comb begin
    out_pc_o    = pc_q[rd_ptr_q];
    out_instr_o = instr_q[rd_ptr_q];
    out_len32_o = len_q[rd_ptr_q];
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: sequential fetch, backpressure, redirects, PC wrap, mid-run reset.
module tb_fetch_queue;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        mem_req, mem_req_w;
  logic [7:0]  mem_addr, mem_addr_w;
  logic [31:0] mem_rdata, mem_rdata_w;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid, out_valid_w;
  logic        out_ready, out_ready_w;
  logic [63:0] out_pc, out_pc_w;
  logic [31:0] out_instr, out_instr_w;
  logic        out_len32, out_len32_w;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  fetch_queue #(.XLEN(64), .ADDR_W(8), .DEPTH(4), .RESET_PC(64'h0)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .mem_req_o       (mem_req),
    .mem_addr_o      (mem_addr),
    .mem_rdata_i     (mem_rdata),
    .redirect_valid_i(redirect_valid),
    .redirect_pc_i   (redirect_pc),
    .out_valid_o     (out_valid),
    .out_ready_i     (out_ready),
    .out_pc_o        (out_pc),
    .out_instr_o     (out_instr),
    .out_len32_o     (out_len32)
  );

  fetch_queue #(.XLEN(64), .ADDR_W(8), .DEPTH(4),
                .RESET_PC(64'hFFFF_FFFF_FFFF_FFFE)) dut_wrap (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .mem_req_o       (mem_req_w),
    .mem_addr_o      (mem_addr_w),
    .mem_rdata_i     (mem_rdata_w),
    .redirect_valid_i(1'b0),
    .redirect_pc_i   (64'h0),
    .out_valid_o     (out_valid_w),
    .out_ready_i     (out_ready_w),
    .out_pc_o        (out_pc_w),
    .out_instr_o     (out_instr_w),
    .out_len32_o     (out_len32_w)
  );

  function automatic logic [31:0] parcel(input logic [7:0] a);
    case (a)
      8'h00:   return 32'hC000_0001;
      8'h04:   return 32'h1234_5678;
      8'h06:   return 32'hFFFF_FFFF;
      8'h40:   return 32'h8000_1111;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  always @(posedge clk_i) begin
    mem_rdata   <= mem_req   ? parcel(mem_addr)   : 32'hDEAD_BEEF;
    mem_rdata_w <= mem_req_w ? parcel(mem_addr_w) : 32'hDEAD_BEEF;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Holds reset for one cycle, then releases it right after the edge that sampled it low.
  task automatic do_reset(input logic ready);
    tick();
    rst_ni         = 1'b0;
    redirect_valid = 1'b0;
    out_ready      = ready;
    #2;
    check_eq("rst_mem_req", 64'(mem_req), 64'h0);
    check_eq("rst_out_valid", 64'(out_valid), 64'h0);
    tick();
    rst_ni = 1'b1;
  endtask

  logic [63:0] seq_pc  [4] = '{64'd0, 64'd4, 64'd6, 64'd10};
  logic        seq_len [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  logic [63:0] bp_pc   [6] = '{64'd0, 64'd4, 64'd6, 64'd10, 64'd14, 64'd18};
  logic [63:0] bp_addr [3] = '{64'd4, 64'd6, 64'd10};

  initial begin
    rst_ni         = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;
    out_ready_w    = 1'b1;
    repeat (2) tick();

    // Sequential mix, plus wrap-around on the second instance
    do_reset(1'b1);
    #2;
    check_eq("seq_c0_req", 64'(mem_req), 64'h1);
    check_eq("seq_c0_addr", 64'(mem_addr), 64'h0);
    check_eq("seq_c0_valid", 64'(out_valid), 64'h0);
    check_eq("wrap_c0_addr", 64'(mem_addr_w), 64'hFE);
    tick(); #2;
    check_eq("seq_c1_addr", 64'(mem_addr), 64'h4);
    check_eq("seq_c1_valid", 64'(out_valid), 64'h0);
    check_eq("wrap_c1_addr", 64'(mem_addr_w), 64'h02);
    for (int i = 0; i < 4; i++) begin
      tick(); #2;
      check_eq("seq_valid", 64'(out_valid), 64'h1);
      check_eq("seq_pc", out_pc, seq_pc[i]);
      check_eq("seq_len", 64'(out_len32), 64'(seq_len[i]));
      if (i == 1) check_eq("seq_instr16", 64'(out_instr), 64'h1234_0000);
      if (i == 0) begin
        check_eq("seq_instr32", 64'(out_instr), 64'hC000_0001);
        check_eq("wrap_pc0", out_pc_w, 64'hFFFF_FFFF_FFFF_FFFE);
      end
      if (i == 1) check_eq("wrap_pc1", out_pc_w, 64'h2);
    end

    // Backpressure fills exactly DEPTH entries, then resumes without gap
    do_reset(1'b0);
    #2;
    check_eq("bp_c0_addr", 64'(mem_addr), 64'h0);
    for (int i = 0; i < 3; i++) begin
      tick(); #2;
      check_eq("bp_req", 64'(mem_req), 64'h1);
      check_eq("bp_addr", 64'(mem_addr), bp_addr[i]);
    end
    for (int i = 0; i < 3; i++) begin
      tick(); #2;
      check_eq("bp_full_req", 64'(mem_req), 64'h0);
      check_eq("bp_full_head", out_pc, 64'h0);
    end
    tick();
    out_ready = 1'b1;
    #2;
    check_eq("bp_release_req", 64'(mem_req), 64'h1);
    check_eq("bp_release_addr", 64'(mem_addr), 64'd14);
    check_eq("bp_release_pc", out_pc, bp_pc[0]);
    for (int i = 1; i < 6; i++) begin
      tick(); #2;
      check_eq("bp_drain_valid", 64'(out_valid), 64'h1);
      check_eq("bp_drain_pc", out_pc, bp_pc[i]);
    end

    // Redirect with a full queue
    do_reset(1'b0);
    repeat (6) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h41;
    #2;
    check_eq("rdf_req", 64'(mem_req), 64'h1);
    check_eq("rdf_addr", 64'(mem_addr), 64'h40);
    tick();
    redirect_valid = 1'b0;
    #2;
    check_eq("rdf_gap_valid", 64'(out_valid), 64'h0);
    check_eq("rdf_next_addr", 64'(mem_addr), 64'h42);
    tick();
    out_ready = 1'b1;
    #2;
    check_eq("rdf_valid", 64'(out_valid), 64'h1);
    check_eq("rdf_pc", out_pc, 64'h40);
    check_eq("rdf_instr", 64'(out_instr), 64'h8000_0000);
    check_eq("rdf_len", 64'(out_len32), 64'h0);
    tick(); #2;
    check_eq("rdf_pc2", out_pc, 64'h42);
    check_eq("rdf_len2", 64'(out_len32), 64'h1);

    // Redirect while a response is in flight, decode ready
    do_reset(1'b1);
    repeat (4) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h40;
    #2;
    check_eq("rdi_head", out_pc, 64'd6);
    check_eq("rdi_addr", 64'(mem_addr), 64'h40);
    tick();
    redirect_valid = 1'b0;
    #2;
    check_eq("rdi_gap_valid", 64'(out_valid), 64'h0);
    tick(); #2;
    check_eq("rdi_valid", 64'(out_valid), 64'h1);
    check_eq("rdi_pc", out_pc, 64'h40);
    tick(); #2;
    check_eq("rdi_pc2", out_pc, 64'h42);

    // One-cycle reset mid-stream
    tick();
    rst_ni = 1'b0;
    #2;
    check_eq("mrst_valid", 64'(out_valid), 64'h0);
    check_eq("mrst_req", 64'(mem_req), 64'h0);
    tick();
    rst_ni = 1'b1;
    #2;
    check_eq("mrst_c0_req", 64'(mem_req), 64'h1);
    check_eq("mrst_c0_addr", 64'(mem_addr), 64'h0);
    check_eq("mrst_c0_valid", 64'(out_valid), 64'h0);
    tick(); #2;
    check_eq("mrst_c1_valid", 64'(out_valid), 64'h0);
    tick(); #2;
    check_eq("mrst_c2_valid", 64'(out_valid), 64'h1);
    check_eq("mrst_c2_pc", out_pc, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
